mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and access sequencer for the shared 256x8 single-port main memory. Lets the CPU port (port 0) and the loader/IO port (port 1) share the memory via req/ack handshakes. It drives the memory's address, write data and write enable. The memory's read port samples on `posedge clk` and returns registered data; its write port commits on `negedge clk`. Sits between the CPU/loader and the memory instance.

## Interface
- `PRIO_FIRST` (default 0): port that wins the first contention after reset; the round-robin pointer resets to this value.
- `clk`  in  1  system clock; all state on `posedge`.
- `reset_n`  in  1  asynchronous active-low reset.
- `req0`, `req1`  in  1 each  access request from port 0 / port 1.
- `we0`, `we1`  in  1 each  1 = write, 0 = read.
- `addr0`, `addr1`  in  8 each  byte address.
- `wdata0`, `wdata1`  in  8 each  write data.
- `ack0`, `ack1`  out  1 each  one-cycle completion pulse; at most one is high.
- `rdata`  out  8  read data; valid only while the matching ack is high.
- `busy`  out  1  high in ISSUE and DONE.
- `mem_addr`  out  8  to memory `address`.
- `mem_wdata`  out  8  to memory `data_in`.
- `mem_we`  out  1  to memory `write_enable`.
- `mem_rdata`  in  8  from memory `data_out`.

## Operation
- FSM states: IDLE, ISSUE, DONE.
- **IDLE**
  - No req: stay in IDLE.
  - One req: that port wins.
  - Both req: the port equal to `rr_ptr` wins.
  - On winning: latch the winner's addr, wdata and we into `mem_addr`, `mem_wdata`, `mem_we`; record the winner index; go to ISSUE.
- **ISSUE**
  - Memory signals are held stable for the full cycle.
  - A write commits at the mid-cycle negedge.
  - The memory samples `mem_addr` at the closing posedge.
  - Go to DONE.
- **DONE**
  - `ack[winner]` = 1 and `rdata` = `mem_rdata`.
  - `mem_we` = 0.
  - `rr_ptr` <= ~winner.
  - Go to IDLE.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until ack is sampled high.
  - Drop req in the same cycle ack is seen, or keep it high to request a new access. Req is re-evaluated in IDLE only.
- `rdata` during a write ack is don't-care. Benches must not check it.
- A req that drops while waiting (never granted) is simply not served; no error.
- `rr_ptr` updates only on completion, so there is no starvation: under continuous contention, grants alternate 0,1,0,1…

## Timing
- Reset (async, immediate): state = IDLE, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `ack0` = `ack1` = 0, `rdata` = 0, `busy` = 0, `rr_ptr` = `PRIO_FIRST`.
- Latency: req sampled at edge E0 in IDLE → ack high during the cycle after E1 (sampled at E2). Two cycles request-to-ack.
- Throughput: one access per 3 cycles.
- Reset during ISSUE before the negedge: `mem_we` drops asynchronously, the write is suppressed, and no ack is issued.
- Reset during DONE: the ack pulse is truncated. The requester must re-request.
- `mem_we` is high only in ISSUE, never across two consecutive negedges, and never in IDLE or DONE.
- `rdata` in DONE is combinational from `mem_rdata`. It must not be registered, to avoid adding a cycle.

## Structure
- Package `mem_arb_pkg`:
  - state encoding: IDLE = 2'd0, ISSUE = 2'd1, DONE = 2'd2;
  - `ADDR_W` = 8, `DATA_W` = 8;
  - port index constants `PORT_CPU` = 0, `PORT_LDR` = 1.
- Sub-module `mem_arb_rr`: purely combinational 2-way round-robin pick (req0, req1, rr_ptr → grant_valid, grant_idx).
- `mem_arbiter` holds the FSM, the latches and the pointer.

## Test plan
- **Single write then read.** Port 0 writes 0xA5 to 0x10 (one access), then reads 0x10. Required: `ack0` pulses 2 cycles after each req; the read returns `rdata` = 0xA5; `ack1` stays 0.
- **Contention after reset (`PRIO_FIRST` = 0).** Both ports read simultaneously: port 0 at 0x00 (preloaded 0x11), port 1 at 0x01 (preloaded 0x22). Required: port 0 is acked first with 0x11, then port 1 three cycles later with 0x22.
- **Sustained contention.** Both ports hold req for 12 accesses. Required: acks alternate 0,1,0,1…; each port gets exactly 6; never two acks in one cycle.
- **Reset abort.** Port 1 writes 0xFF to 0x20 (preloaded 0x00); assert `reset_n` = 0 in ISSUE before the negedge. Required: all outputs return to reset values immediately; a later read of 0x20 returns 0x00.
- **Back-to-back from one port.** Port 0 keeps req high across ack with new addresses 0x30, 0x31, 0x32. Required: acks spaced exactly 3 cycles apart; `mem_addr` sequence is 0x30, 0x31, 0x32.
- **Write-enable check.** Monitor `mem_we` across all tests. Required: high only in ISSUE, never across two consecutive negedges.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port main-memory arbiter.
// State encoding is fixed so debug tooling can decode the raw state register.
package mem_arb_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_LDR = 1'b1;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef struct packed {
      logic  we;
      addr_t addr;
      data_t wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled as one interface.
// slave = arbiter view; master = requesters plus the memory instance.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic  req0;
   logic  req1;
   logic  we0;
   logic  we1;
   addr_t addr0;
   addr_t addr1;
   data_t wdata0;
   data_t wdata1;
   logic  ack0;
   logic  ack1;
   data_t rdata;
   logic  busy;
   addr_t mem_addr;
   data_t mem_wdata;
   logic  mem_we;
   data_t mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      output ack0, ack1, rdata, busy, mem_addr, mem_wdata, mem_we
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rdata, busy, mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/mem_arb_rr.sv
// Combinational 2-way round-robin pick: a lone requester always wins,
// on contention the port named by the pointer wins.
module mem_arb_rr
   import mem_arb_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_rr_ptr,
   output logic o_grant_valid,
   output logic o_grant_idx
);

   always_comb begin
      o_grant_valid = i_req0 | i_req1;
      o_grant_idx   = PORT_CPU;
      if (i_req0 && i_req1) begin
         o_grant_idx = i_rr_ptr;
      end else if (i_req1) begin
         o_grant_idx = PORT_LDR;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter and access sequencer for the shared 256x8 main memory.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | waiting for a request; arbitration happens only here
//   ST_ISSUE | memory command held stable; write commits at mid-cycle negedge
//   ST_DONE  | ack to the winner, rdata passed through, pointer advanced
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter logic PRIO_FIRST = 1'b0
) (
   input  logic           clk,
   input  logic           reset_n,
   mem_arbiter_if.slave   bus
);

   logic [1:0] r_state;
   logic       r_rr_ptr;
   logic       r_winner;
   logic       r_mem_we;
   addr_t      r_mem_addr;
   data_t      r_mem_wdata;

   logic       w_grant_valid;
   logic       w_grant_idx;
   mem_cmd_t   w_cmd;

   mem_arb_rr u_rr (
      .i_req0        (bus.req0),
      .i_req1        (bus.req1),
      .i_rr_ptr      (r_rr_ptr),
      .o_grant_valid (w_grant_valid),
      .o_grant_idx   (w_grant_idx)
   );

   always_comb begin
      w_cmd = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0};
      if (w_grant_idx == PORT_LDR) begin
         w_cmd = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1};
      end
   end

   // mem_we is registered so it is high for exactly the ISSUE cycle and
   // drops asynchronously on reset, suppressing a pending write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= PRIO_FIRST;
         r_winner    <= PORT_CPU;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_valid) begin
                  r_mem_addr  <= w_cmd.addr;
                  r_mem_wdata <= w_cmd.wdata;
                  r_mem_we    <= w_cmd.we;
                  r_winner    <= w_grant_idx;
                  r_state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_mem_we <= 1'b0;
               r_state  <= ST_DONE;
            end
            ST_DONE: begin
               r_rr_ptr <= ~r_winner;
               r_state  <= ST_IDLE;
            end
            default: begin
               r_mem_we <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_we    = r_mem_we;
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.ack0      = (r_state == ST_DONE) && (r_winner == PORT_CPU);
   assign bus.ack1      = (r_state == ST_DONE) && (r_winner == PORT_LDR);
   // Pass-through keeps request-to-ack at two cycles.
   assign bus.rdata     = (r_state == ST_DONE) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 memory model
// (registered read on posedge, write on negedge).
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter #(.PRIO_FIRST(1'b0)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [7:0] mem [256];
   logic       prev_we = 1'b0;
   int         n_checks = 0;
   int         n_errors = 0;

   always @(negedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
   always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // mem_we may only be high in ISSUE (busy with no ack) and never at two consecutive negedges
   always @(negedge clk) begin
      chk("we_consec", 32'(bus.mem_we & prev_we), 32'd0);
      chk("we_outside_issue", 32'(bus.mem_we & ~(bus.busy & ~bus.ack0 & ~bus.ack1)), 32'd0);
      prev_we = bus.mem_we;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
      chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
      chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
      chk({tag, "_ack0"},      32'(bus.ack0),      32'd0);
      chk({tag, "_ack1"},      32'(bus.ack1),      32'd0);
      chk({tag, "_rdata"},     32'(bus.rdata),     32'd0);
      chk({tag, "_busy"},      32'(bus.busy),      32'd0);
   endtask

   task automatic drop_all();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      bus.we0  = 1'b0;
      bus.we1  = 1'b0;
   endtask

   // Single access from one port; expects ack two cycles after the request.
   task automatic run_access(input string tag, input logic port, input logic we,
                             input logic [7:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rd);
      logic seen;
      logic ack_me;
      logic ack_other;
      if (port == 1'b0) begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
      end else begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
      end
      seen = 1'b0;
      for (int n = 1; n <= 8 && !seen; n++) begin
         tick();
         ack_me    = (port == 1'b0) ? bus.ack0 : bus.ack1;
         ack_other = (port == 1'b0) ? bus.ack1 : bus.ack0;
         chk({tag, "_other_ack"}, 32'(ack_other), 32'd0);
         if (ack_me) begin
            seen = 1'b1;
            chk({tag, "_latency"}, 32'(n), 32'd2);
            chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(addr));
            if (!we) chk({tag, "_rdata"}, 32'(bus.rdata), 32'(exp_rd));
            drop_all();
         end
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         drop_all();
      end
      repeat (2) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got0, got1;
      int   acks, last, c0, c1, k;

      reset_n = 1'b1;
      bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h00] = 8'h11;
      mem[8'h01] = 8'h22;
      mem[8'h30] = 8'hC0;
      mem[8'h31] = 8'hC1;
      mem[8'h32] = 8'hC2;

      #2 reset_n = 1'b0;
      #1 chk_reset_vals("rst");
      repeat (3) tick();
      reset_n = 1'b1;
      tick();

      // contention right after reset: port 0 first, port 1 three cycles later
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h00;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h01;
      got0 = 1'b0; got1 = 1'b0;
      for (int n = 1; n <= 12 && !(got0 && got1); n++) begin
         tick();
         chk("cont_dual_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
         if (bus.ack0) begin
            chk("cont_ack0_cycle", 32'(n), 32'd2);
            chk("cont_ack0_rdata", 32'(bus.rdata), 32'h11);
            bus.req0 = 1'b0; got0 = 1'b1;
         end
         if (bus.ack1) begin
            chk("cont_ack1_cycle", 32'(n), 32'd5);
            chk("cont_ack1_rdata", 32'(bus.rdata), 32'h22);
            bus.req1 = 1'b0; got1 = 1'b1;
         end
      end
      chk("cont_both_served", 32'(got0 & got1), 32'd1);
      drop_all();
      repeat (2) tick();

      // sustained contention, 12 accesses
      bus.req0 = 1'b1; bus.addr0 = 8'h00;
      bus.req1 = 1'b1; bus.addr1 = 8'h01;
      acks = 0; last = 0; c0 = 0; c1 = 0;
      for (int n = 1; n <= 60 && acks < 12; n++) begin
         tick();
         chk("sus_dual_ack", 32'(bus.ack0 & bus.ack1), 32'd0);
         if (bus.ack0 || bus.ack1) begin
            chk("sus_order", 32'(bus.ack1), 32'(acks % 2));
            chk("sus_spacing", 32'(n - last), (acks == 0) ? 32'd2 : 32'd3);
            chk("sus_rdata", 32'(bus.rdata), bus.ack0 ? 32'h11 : 32'h22);
            last = n;
            if (bus.ack0) c0++; else c1++;
            acks++;
            if (acks == 12) drop_all();
         end
      end
      drop_all();
      chk("sus_count0", 32'(c0), 32'd6);
      chk("sus_count1", 32'(c1), 32'd6);
      repeat (2) tick();

      // single write then read from port 0
      run_access("wr10", 1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
      chk("wr10_mem", 32'(mem[8'h10]), 32'hA5);
      run_access("rd10", 1'b0, 1'b0, 8'h10, 8'h00, 8'hA5);

      // back-to-back reads from port 0 with req held across ack
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h30;
      k = 0; last = 0;
      for (int n = 1; n <= 20 && k < 3; n++) begin
         tick();
         chk("b2b_ack1", 32'(bus.ack1), 32'd0);
         if (bus.ack0) begin
            chk("b2b_spacing", 32'(n - last), (k == 0) ? 32'd2 : 32'd3);
            chk("b2b_mem_addr", 32'(bus.mem_addr), 32'(8'h30 + k));
            chk("b2b_rdata", 32'(bus.rdata), 32'(8'hC0 + k));
            last = n;
            k++;
            if (k < 3) bus.addr0 = 8'(8'h30 + k);
            else bus.req0 = 1'b0;
         end
      end
      drop_all();
      chk("b2b_count", 32'(k), 32'd3);
      repeat (2) tick();

      // reset abort during ISSUE before the write negedge
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 8'hFF;
      tick();
      chk("abort_we_in_issue", 32'(bus.mem_we), 32'd1);
      reset_n = 1'b0;
      #1 chk_reset_vals("abort");
      drop_all();
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      chk("abort_mem_model", 32'(mem[8'h20]), 32'h00);
      run_access("abort_rd", 1'b1, 1'b0, 8'h20, 8'h00, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
